// File: rtl/dds_phase_accumulator.sv
// DDS phase accumulator.
// Integrates a frequency tuning word every enabled clock and presents the top
// PHASE_BIT bits of the accumulator, plus a phase offset, as a registered ROM
// address. New tuning words are double-buffered: accepted into a shadow
// register and moved into the active register only at a safe point (wrap edge,
// while halted, while the active word is zero, or on a phase clear). This keeps
// frequency changes glitch-free.

`ifndef ROM_PHASE_BIT
`define ROM_PHASE_BIT 10
`endif

module dds_phase_accumulator #(
  parameter int ACC_BIT   = 32,
  parameter int PHASE_BIT = `ROM_PHASE_BIT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 sync,
  input  logic [ACC_BIT-1:0]   ftw_in,
  input  logic                 ftw_valid,
  output logic                 ftw_ready,
  input  logic [PHASE_BIT-1:0] poff,
  output logic [PHASE_BIT-1:0] phase,
  output logic                 wrap
);

  logic [ACC_BIT-1:0]   acc_q, acc_d;
  logic [ACC_BIT-1:0]   ftw_act_q, ftw_act_d;
  logic [ACC_BIT-1:0]   ftw_shd_q, ftw_shd_d;
  logic                 pend_q, pend_d;
  logic [PHASE_BIT-1:0] phase_q, phase_d;
  logic                 wrap_q, wrap_d;
  logic [ACC_BIT:0]     sum;
  logic                 carry;
  logic                 accept;
  logic                 transfer;

  // Accumulator update: add the active word when enabled, phase clear wins over enable.
  always_comb begin
    sum     = {1'b0, acc_q} + {1'b0, ftw_act_q};
    acc_d   = acc_q;
    carry   = 1'b0;
    if (sync) begin
      acc_d = '0;
      carry = 1'b0;
    end else if (en) begin
      acc_d = sum[ACC_BIT-1:0];
      carry = sum[ACC_BIT];
    end
    phase_d = acc_d[ACC_BIT-1 -: PHASE_BIT] + poff;
    wrap_d  = carry;
  end

  // Tuning word handshake: accept into the shadow, move to active only at a safe point.
  always_comb begin
    accept    = ftw_valid & ~pend_q;
    transfer  = pend_q & (carry | ~en | (ftw_act_q == '0) | sync);
    ftw_act_d = ftw_act_q;
    ftw_shd_d = ftw_shd_q;
    pend_d    = pend_q;
    if (transfer) begin
      ftw_act_d = ftw_shd_q;
      pend_d    = 1'b0;
    end
    if (accept) begin
      ftw_shd_d = ftw_in;
      pend_d    = 1'b1;
    end
  end

  // State registers with immediate reset; reset discards any pending word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q     <= '0;
      ftw_act_q <= '0;
      ftw_shd_q <= '0;
      pend_q    <= 1'b0;
      phase_q   <= '0;
      wrap_q    <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      ftw_act_q <= ftw_act_d;
      ftw_shd_q <= ftw_shd_d;
      pend_q    <= pend_d;
      phase_q   <= phase_d;
      wrap_q    <= wrap_d;
    end
  end

  assign ftw_ready = ~pend_q;
  assign phase     = phase_q;
  assign wrap      = wrap_q;

endmodule

// File: tb/tb_dds_phase_accumulator.sv
// Testbench for dds_phase_accumulator (ACC_BIT=32, PHASE_BIT=10).
// A behavioural reference computes the expected phase, wrap and ready from
// plain modular arithmetic; directed scenarios pin known literal values and a
// randomized phase exercises enable, phase clear, offsets and tuning words.

module tb_dds_phase_accumulator;

  localparam int ACC_BIT   = 32;
  localparam int PHASE_BIT = 10;
  localparam longint unsigned MOD = 64'h1_0000_0000;

  logic                 clk;
  logic                 rst;
  logic                 en;
  logic                 sync;
  logic [ACC_BIT-1:0]   ftw_in;
  logic                 ftw_valid;
  logic                 ftw_ready;
  logic [PHASE_BIT-1:0] poff;
  logic [PHASE_BIT-1:0] phase;
  logic                 wrap;

  int errors = 0;
  int checks = 0;
  bit checkOn = 1'b0;

  // Reference state: accumulator value, active and shadow words, pending flag.
  longint unsigned mAcc, mAct, mShd;
  bit              mPend;
  int              mPhase;
  bit              mWrap;
  longint unsigned mTotal;
  bit              mCarry;
  bit              mXfer;
  bit              mAccept;

  dds_phase_accumulator #(
    .ACC_BIT  (ACC_BIT),
    .PHASE_BIT(PHASE_BIT)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .sync     (sync),
    .ftw_in   (ftw_in),
    .ftw_valid(ftw_valid),
    .ftw_ready(ftw_ready),
    .poff     (poff),
    .phase    (phase),
    .wrap     (wrap)
  );

  // Free-running clock, 10 time units per period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: next phase is the integrated frequency modulo 2^32, truncated and offset.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mAcc   = 0;
      mAct   = 0;
      mShd   = 0;
      mPend  = 1'b0;
      mPhase = 0;
      mWrap  = 1'b0;
    end else begin
      mTotal = en ? (mAcc + mAct) : mAcc;
      mCarry = (mTotal >= MOD);
      if (sync) begin
        mTotal = 0;
        mCarry = 1'b0;
      end
      mXfer   = mPend && (mCarry || !en || mAct == 0 || sync);
      mAccept = ftw_valid && !mPend;
      if (mXfer) begin
        mAct  = mShd;
        mPend = 1'b0;
      end
      if (mAccept) begin
        mShd  = 64'(ftw_in);
        mPend = 1'b1;
      end
      mAcc   = mTotal % MOD;
      mPhase = int'(((mAcc >> (ACC_BIT - PHASE_BIT)) + 64'(poff)) % 1024);
      mWrap  = mCarry;
    end
  end

  task automatic checkOutput(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Compare process: every cycle outside reset, DUT outputs must match the reference.
  initial begin
    forever begin
      @(negedge clk);
      if (checkOn && !rst) begin
        checkOutput("model.phase", longint'(phase), longint'(mPhase));
        checkOutput("model.wrap", longint'(wrap), longint'(mWrap));
        checkOutput("model.ftw_ready", longint'(ftw_ready), longint'(!mPend));
      end
    end
  end

  // Drive one cycle worth of inputs, then wait for the next falling edge.
  task automatic applyStimulus(input bit enV, input bit syncV, input bit validV,
                               input logic [ACC_BIT-1:0] ftwV, input logic [PHASE_BIT-1:0] poffV);
    en        = enV;
    sync      = syncV;
    ftw_valid = validV;
    ftw_in    = ftwV;
    poff      = poffV;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    en = 1'b0; sync = 1'b0; ftw_valid = 1'b0; ftw_in = '0; poff = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checkOn = 1'b1;
    checkOutput("reset.phase", longint'(phase), 0);
    checkOutput("reset.wrap", longint'(wrap), 0);
    checkOutput("reset.ready", longint'(ftw_ready), 1);

    // Load 2^22 while halted, then run a full phase period.
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h0040_0000, 10'd0);
    checkOutput("loadHalt.readyLow", longint'(ftw_ready), 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 10'd0);
    checkOutput("loadHalt.readyBack", longint'(ftw_ready), 1);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 10'd0);
    checkOutput("run22.first", longint'(phase), 1);
    repeat (1022) applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 10'd0);
    checkOutput("run22.last", longint'(phase), 1023);
    checkOutput("run22.noWrap", longint'(wrap), 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 10'd0);
    checkOutput("run22.wrapPhase", longint'(phase), 0);
    checkOutput("run22.wrap", longint'(wrap), 1);

    // Phase clear with an offset, then resume counting from zero.
    repeat (7) applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 10'd0);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 10'd5);
    checkOutput("sync.phase", longint'(phase), 5);
    checkOutput("sync.wrap", longint'(wrap), 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 10'd0);
    checkOutput("sync.resume", longint'(phase), 1);
    repeat (5) applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 10'd0);

    // Asynchronous reset in the middle of a count takes effect before the next edge.
    en = 1'b0;
    #2 rst = 1'b1;
    #1;
    checkOutput("asyncRst.phase", longint'(phase), 0);
    checkOutput("asyncRst.wrap", longint'(wrap), 0);
    checkOutput("asyncRst.ready", longint'(ftw_ready), 1);
    @(negedge clk);
    rst = 1'b0;

    // Active word zero: a loaded word transfers without waiting for a wrap.
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h0040_0000, 10'd0);
    checkOutput("zeroAct.readyLow", longint'(ftw_ready), 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 10'd0);
    checkOutput("zeroAct.readyBack", longint'(ftw_ready), 1);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 10'd0);
    checkOutput("zeroAct.counting", longint'(phase), 1);

    // Step 4 running; load step 2 at phase 100, which waits for the wrap.
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h0100_0000, 10'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 10'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 10'd0);
    repeat (25) applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 10'd0);
    checkOutput("step4.phase100", longint'(phase), 100);
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h0080_0000, 10'd0);
    checkOutput("step4.stillStep4", longint'(phase), 104);
    checkOutput("step4.readyLow", longint'(ftw_ready), 0);
    repeat (229) applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 10'd0);
    checkOutput("step4.preWrap", longint'(phase), 1020);
    checkOutput("step4.preWrapReady", longint'(ftw_ready), 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 10'd0);
    checkOutput("step4.wrapPhase", longint'(phase), 0);
    checkOutput("step4.wrap", longint'(wrap), 1);
    checkOutput("step4.readyAfterXfer", longint'(ftw_ready), 1);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 10'd0);
    checkOutput("step2.first", longint'(phase), 2);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 10'd0);
    checkOutput("step2.second", longint'(phase), 4);

    // Offset 1020: wrap follows the accumulator overflow, not phase zero.
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 10'd1020);
    checkOutput("poff.start", longint'(phase), 1020);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 10'd1020);
    checkOutput("poff.next", longint'(phase), 1022);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 10'd1020);
    checkOutput("poff.zeroNoWrap", longint'(wrap), 0);
    repeat (509) applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 10'd1020);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 10'd1020);
    checkOutput("poff.wrapPhase", longint'(phase), 1020);
    checkOutput("poff.wrap", longint'(wrap), 1);

    // Randomized operation against the reference model.
    for (int i = 0; i < 4000; i++) begin
      logic [ACC_BIT-1:0] ftwR;
      logic [PHASE_BIT-1:0] poffR;
      case ($urandom % 3)
        0:       ftwR = $urandom;
        1:       ftwR = 32'(1) << $urandom_range(18, 31);
        default: ftwR = 32'(1) << $urandom_range(12, 22);
      endcase
      poffR = ($urandom % 16 == 0) ? PHASE_BIT'($urandom) : poff;
      if ($urandom % 700 == 0) begin
        #1 rst = 1'b1;
        #2 rst = 1'b0;
      end
      applyStimulus(($urandom % 8) != 0, ($urandom % 64) == 0, ($urandom % 4) == 0, ftwR, poffR);
    end

    checkOn = 1'b0;
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
